// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg : shared state encoding and op-codes for calc_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GET_A = 3'd1,
        ST_GET_B = 3'd2,
        ST_CALC  = 3'd3,
        ST_SHOW  = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/calc_alu.sv
// ---------------------------------------------------------------------------
// calc_alu : combinational add/sub/and/or with signed overflow flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] sum,
    output logic             ovr
);

    always_comb begin
        sum = '0;
        ovr = 1'b0;
        case (op)
            OP_ADD: begin
                sum = a + b;
                ovr = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum = a - b;
                ovr = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: sum = a & b;
            default: sum = a | b;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer : Enter-stepped two-operand calculator with result chaining
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHAIN = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enter,
    input  logic             ClearEntry,
    input  logic [1:0]       OpSel,
    input  logic [WIDTH-1:0] DataIn,
    output logic [2:0]       State,
    output logic [WIDTH-1:0] Result,
    output logic             OVR,
    output logic             Done,
    output logic [WIDTH-1:0] Display
);

    state_t           state_q, state_d;
    logic             enter_q;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ovr_q, ovr_d;
    logic             done_q, done_d;

    logic             rise;
    logic [WIDTH-1:0] alu_sum;
    logic             alu_ovr;

    assign rise = Enter & ~enter_q;

    calc_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .sum (alu_sum),
        .ovr (alu_ovr)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        r_d     = r_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;

        if (ClearEntry) begin
            state_d = ST_IDLE;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            r_d     = '0;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (rise) state_d = ST_GET_A;
                ST_GET_A: if (rise) begin
                    a_d     = DataIn;
                    state_d = ST_GET_B;
                end
                ST_GET_B: if (rise) begin
                    b_d     = DataIn;
                    op_d    = OpSel;
                    state_d = ST_CALC;
                end
                // CALC never looks at rise; it always completes in one cycle.
                ST_CALC: begin
                    r_d     = alu_sum;
                    ovr_d   = alu_ovr;
                    done_d  = 1'b1;
                    state_d = ST_SHOW;
                end
                ST_SHOW: if (rise) begin
                    if (CHAIN != 0) begin
                        a_d     = r_q;
                        state_d = ST_GET_B;
                    end else begin
                        state_d = ST_GET_A;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            enter_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            r_q     <= '0;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= Enter;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            r_q     <= r_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
        end
    end

    assign State   = state_q;
    assign Result  = r_q;
    assign OVR     = ovr_q;
    assign Done    = done_q;
    assign Display = (state_q == ST_SHOW) ? r_q : DataIn;

endmodule

`default_nettype wire
